// File: rtl/i_mem_lane_wrap.sv
// i_mem_lane_wrap: LANES byte-wide banks that serve a one-cycle fetch at any
// byte-aligned PC, and a ring port with per-byte write masks and a back-pressured
// read-response queue. Defining I_MEM_PARITY_EN adds per-byte even parity.

package lotr_pkg;
    localparam int MSB_REGION = 31;
    localparam int LSB_REGION = 12;
    localparam logic [MSB_REGION-LSB_REGION:0] I_MEM_REGION = '0;

    typedef enum logic [1:0] {
        RD = 2'b00,
        WR = 2'b01
    } t_opcode;
endpackage

// One byte bank with two ports: A is the fetch read port, B is the ring port.
// A read on either port returns the contents from before a same-edge B write.
module i_mem_lane_bank #(
    parameter int ROW_W = 10,
    parameter int DW    = 8
) (
    input  logic             clk,
    input  logic             a_en,
    input  logic [ROW_W-1:0] a_row,
    output logic [DW-1:0]    a_dout,
    input  logic             b_en,
    input  logic             b_we,
    input  logic [ROW_W-1:0] b_row,
    input  logic [DW-1:0]    b_din,
    output logic [DW-1:0]    b_dout
);
    logic [DW-1:0] mem [2**ROW_W];

    // Synchronous reads on both ports; ring write on port B
    always_ff @(posedge clk) begin
        if (a_en) a_dout <= mem[a_row];
        if (b_en) b_dout <= mem[b_row];
        if (b_we) mem[b_row] <= b_din;
    end
endmodule

module i_mem_lane_wrap
    import lotr_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int ADDR_W    = 12,
    parameter int RSP_DEPTH = 2
) (
    input  logic                 QClk,
    input  logic                 RstQnnnH,
    input  logic [31:0]          PcQ100H,
    input  logic                 RdEnableQ100H,
    output logic [8*LANES-1:0]   InstFetchQ101H,
    input  logic                 F2C_ReqValidQ503H,
    output logic                 F2C_ReqReadyQ503H,
    input  t_opcode              F2C_ReqOpcodeQ503H,
    input  logic [31:0]          F2C_ReqAddressQ503H,
    input  logic [8*LANES-1:0]   F2C_ReqDataQ503H,
    input  logic [LANES-1:0]     F2C_ReqByteEnQ503H,
    input  logic                 F2C_ReqParInjQ503H,
    output logic                 F2C_RspIMemValidQ504H,
    input  logic                 F2C_RspIMemReadyQ504H,
    output logic [8*LANES-1:0]   F2C_I_MemRspDataQ504H,
    output logic                 IMemParErrQ101H,
    output logic                 IMemParErrStickyQ
);
    localparam int LANE_W = $clog2(LANES);
    localparam int ROW_W  = ADDR_W - LANE_W;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
`ifdef I_MEM_PARITY_EN
    localparam int DW = 9;
`else
    localparam int DW = 8;
`endif

    logic [LANE_W-1:0] pc_lane, r_lane;
    logic [ROW_W-1:0]  pc_row, r_row_base;
    logic              hit, ring_wr, rd_fire, rd_room;
    logic [LANES-1:0][DW-1:0] f_dout, r_dout;

    assign pc_lane    = PcQ100H[LANE_W-1:0];
    assign pc_row     = PcQ100H[ADDR_W-1:LANE_W];
    assign r_lane     = F2C_ReqAddressQ503H[LANE_W-1:0];
    assign r_row_base = F2C_ReqAddressQ503H[ADDR_W-1:LANE_W];

    assign hit     = (F2C_ReqAddressQ503H[MSB_REGION:LSB_REGION] == I_MEM_REGION);
    // Writes never need response space, so only reads are throttled
    assign F2C_ReqReadyQ503H = (F2C_ReqOpcodeQ503H != RD) || rd_room;
    assign ring_wr = F2C_ReqValidQ503H && (F2C_ReqOpcodeQ503H == WR) && hit;
    assign rd_fire = F2C_ReqValidQ503H && F2C_ReqReadyQ503H &&
                     (F2C_ReqOpcodeQ503H == RD) && hit;

    // Lanes below the start lane belong to the next row; the row counter
    // width makes the top of memory wrap back to row 0.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam logic [LANE_W-1:0] LID = LANE_W'(l);
        logic [ROW_W-1:0]  f_row, r_row;
        logic [LANE_W-1:0] r_k;
        logic [7:0]        wbyte;
        logic [DW-1:0]     din;

        assign f_row = pc_row + ROW_W'(LID < pc_lane);
        assign r_row = r_row_base + ROW_W'(LID < r_lane);
        assign r_k   = LID - r_lane;
        assign wbyte = F2C_ReqDataQ503H[r_k*8 +: 8];
`ifdef I_MEM_PARITY_EN
        assign din   = {(^wbyte) ^ F2C_ReqParInjQ503H, wbyte};
`else
        assign din   = wbyte;
`endif

        i_mem_lane_bank #(.ROW_W(ROW_W), .DW(DW)) u_bank (
            .clk    (QClk),
            .a_en   (RdEnableQ100H),
            .a_row  (f_row),
            .a_dout (f_dout[l]),
            .b_en   (rd_fire),
            .b_we   (ring_wr && F2C_ReqByteEnQ503H[r_k]),
            .b_row  (r_row),
            .b_din  (din),
            .b_dout (r_dout[l])
        );
    end

    // ---------------- fetch path ----------------
    logic [LANE_W-1:0]     f_rot_q;
    logic                  f_vld_q;
    logic [LANES-1:0][7:0] f_bytes;

    // Rotation and "ever fetched" only advance with the bank outputs
    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            f_rot_q <= '0;
            f_vld_q <= 1'b0;
        end else if (RdEnableQ100H) begin
            f_rot_q <= pc_lane;
            f_vld_q <= 1'b1;
        end
    end

    // Output byte k comes from lane (a+k) mod LANES
    always_comb begin
        f_bytes = '0;
        for (int k = 0; k < LANES; k++) begin
            logic [LANE_W-1:0] idx;
            idx = f_rot_q + LANE_W'(k);
            f_bytes[k] = f_dout[idx][7:0];
        end
    end

    assign InstFetchQ101H = f_vld_q ? f_bytes : '0;

    // ---------------- ring read / response path ----------------
    logic [LANE_W-1:0]     r_rot_q;
    logic                  rd_inflight;
    logic [LANES-1:0][7:0] r_bytes;
    logic [8*LANES-1:0]    q_mem [RSP_DEPTH];
    logic [PTR_W-1:0]      q_wp, q_rp;
    logic [CNT_W-1:0]      q_cnt;
    logic [CNT_W:0]        occ;
    logic                  q_push, q_pop, q_nempty;

    assign occ     = {1'b0, q_cnt} + (CNT_W+1)'(rd_inflight);
    assign rd_room = occ < (CNT_W+1)'(RSP_DEPTH);

    // One-cycle in-flight tracker for ring reads
    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            rd_inflight <= 1'b0;
            r_rot_q     <= '0;
        end else begin
            rd_inflight <= rd_fire;
            if (rd_fire) r_rot_q <= r_lane;
        end
    end

    // Ring read data uses the same rotation as fetch
    always_comb begin
        r_bytes = '0;
        for (int k = 0; k < LANES; k++) begin
            logic [LANE_W-1:0] idx;
            idx = r_rot_q + LANE_W'(k);
            r_bytes[k] = r_dout[idx][7:0];
        end
    end

    assign q_nempty              = (q_cnt != '0);
    assign F2C_RspIMemValidQ504H = rd_inflight || q_nempty;
    assign F2C_I_MemRspDataQ504H = q_nempty ? q_mem[q_rp] : r_bytes;
    // The in-flight read bypasses the queue only when it is the head and taken
    assign q_push = rd_inflight && (q_nempty || !F2C_RspIMemReadyQ504H);
    assign q_pop  = q_nempty && F2C_RspIMemReadyQ504H;

    // Queue pointers and occupancy
    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            q_wp  <= '0;
            q_rp  <= '0;
            q_cnt <= '0;
        end else begin
            if (q_push) q_wp <= (q_wp == PTR_W'(RSP_DEPTH-1)) ? '0 : q_wp + 1'b1;
            if (q_pop)  q_rp <= (q_rp == PTR_W'(RSP_DEPTH-1)) ? '0 : q_rp + 1'b1;
            q_cnt <= q_cnt + CNT_W'(q_push) - CNT_W'(q_pop);
        end
    end

    // Queue storage, not reset
    always_ff @(posedge QClk) begin
        if (q_push) q_mem[q_wp] <= r_bytes;
    end

    // ---------------- parity ----------------
`ifdef I_MEM_PARITY_EN
    logic             f_chk_q;
    logic [LANES-1:0] lane_bad;
    logic             unused_bits;

    // Check only the cycle after an enabled fetch
    always_ff @(posedge QClk) begin
        if (RstQnnnH) f_chk_q <= 1'b0;
        else          f_chk_q <= RdEnableQ100H;
    end

    // Each stored 9-bit word must have even overall parity
    always_comb begin
        lane_bad = '0;
        for (int l = 0; l < LANES; l++) lane_bad[l] = ^f_dout[l];
    end

    assign IMemParErrQ101H = f_chk_q && (|lane_bad);

    // Sticky flag holds until reset
    always_ff @(posedge QClk) begin
        if (RstQnnnH)             IMemParErrStickyQ <= 1'b0;
        else if (IMemParErrQ101H) IMemParErrStickyQ <= 1'b1;
    end

    // Ring reads are not parity checked
    always_comb begin
        unused_bits = ^PcQ100H[31:ADDR_W];
        for (int l = 0; l < LANES; l++) unused_bits = unused_bits ^ r_dout[l][8];
    end
`else
    logic unused_bits;
    assign unused_bits       = ^{PcQ100H[31:ADDR_W], F2C_ReqParInjQ503H};
    assign IMemParErrQ101H   = 1'b0;
    assign IMemParErrStickyQ = 1'b0;
`endif

endmodule

// File: doc/i_mem_lane_wrap.md
Name: i_mem_lane_wrap

Overview:
Parametrised instruction-memory wrapper for the gpc core tile, the successor of the fixed 4-byte-lane I_MEM wrap. It holds LANES byte-wide banks, so the core can fetch any byte-aligned PC in one cycle. Ring (F2C) accesses support per-byte write masks. Read responses go through a back-pressured response queue. The block sits between the core fetch stage (Q100/Q101) and the ring controller (Q503/Q504).

Parameters:
LANES, 4, number of byte banks and fetch width in bytes; power of 2, range 2..8
ADDR_W, 12, byte-address bits used inside I_MEM; depth of each bank = 2^ADDR_W/LANES
RSP_DEPTH, 2, ring read-response queue entries; range 1..8

Ports:
QClk  in  1  clock
RstQnnnH  in  1  synchronous, active-high reset
PcQ100H  in  32  fetch byte address; any byte alignment allowed
RdEnableQ100H  in  1  fetch enable
InstFetchQ101H  out  8*LANES  fetched bytes; byte k = mem[PC+k]
F2C_ReqValidQ503H  in  1  ring request valid
F2C_ReqReadyQ503H  out  1  ring request accepted when valid and ready
F2C_ReqOpcodeQ503H  in  t_opcode  RD or WR
F2C_ReqAddressQ503H  in  32  byte address
F2C_ReqDataQ503H  in  8*LANES  write data; byte k goes to address+k
F2C_ReqByteEnQ503H  in  LANES  write mask; bit k enables byte k
F2C_ReqParInjQ503H  in  1  parity-error inject; ignored unless the optional feature is compiled in
F2C_RspIMemValidQ504H  out  1  read response valid
F2C_RspIMemReadyQ504H  in  1  consumer ready
F2C_I_MemRspDataQ504H  out  8*LANES  read response data
IMemParErrQ101H  out  1  fetch parity error pulse
IMemParErrStickyQ  out  1  sticky parity error flag

Behaviour:
- Hit = address[MSB_REGION:LSB_REGION] == I_MEM_REGION, using lotr_pkg constants. Requests that miss are accepted (ready honoured), produce no write and no response, and are ignored.
- Banking: byte address a maps to lane a mod LANES and row (a[ADDR_W-1:0])/LANES.
- For access byte k, lane l = (a+k) mod LANES reads/writes row (a+k)/LANES. Rows wrap modulo bank depth, so an access at the top of I_MEM wraps to byte 0.
- The rotation amount a mod LANES is registered for one cycle. Output byte k is taken from lane (a+k) mod LANES of the sync-read data.
- Fetch latency is 1 cycle.
- If RdEnableQ100H=0, InstFetchQ101H holds its previous value. Bank outputs are not re-enabled, so the rotation register also holds.
- Ring WR: every hit write is accepted. Bytes with mask bit 0 are unchanged. Writes produce no response.
- Ring RD: accepted only when F2C_ReqReadyQ503H=1, where ready = (queue count + reads in flight) < RSP_DEPTH. WR requests see ready=1 always.
- Read data is rotated the same way as fetch data and becomes available in Q504.
- Response path, in order: F2C_RspIMemValidQ504H = in-flight read or queue non-empty. Data comes from the queue head if the queue is non-empty, else from the in-flight read.
- If the in-flight read is not consumed (ready=0, or the queue is non-empty), it is pushed into the queue.
- A response is popped on valid && ready. Ordering is strictly FIFO.
- Same-cycle fetch and ring write to the same byte: the write takes effect, and the fetch returns the old byte (read-before-write).
- Same-cycle ring RD to the same bank as a fetch: allowed. The banks are true dual-port, so there is no stall.
- Reset: InstFetchQ101H=0, response queue emptied, in-flight read dropped, F2C_RspIMemValidQ504H=0, parity flags=0. Memory contents are not reset.
- Reset asserted mid-transaction: pending responses are lost, and the next cycle after deassert has ready=1.

Optional Feature:
- Macro I_MEM_PARITY_EN.
- When defined:
  - Each byte stores an even-parity bit, written with each ring write byte. If F2C_ReqParInjQ503H=1, the stored parity is inverted.
  - On an enabled fetch, any lane mismatch pulses IMemParErrQ101H for one cycle in Q101 and sets IMemParErrStickyQ until reset.
  - Ring reads are not checked.
- When undefined: no parity storage; both error outputs are tied to 0 and F2C_ReqParInjQ503H is unused.

Test Plan:
- Unaligned fetch: ring WR 0x03020100 @0x0 and 0x07060504 @0x4; fetch PC=0x1 -> InstFetchQ101H=0x04030201 one cycle later; PC=0x3 -> 0x06050403.
- Masked write: preload 0xAABBCCDD @0x10; WR data 0x11223344, ByteEn=4'b0101 @0x10; RD @0x10 -> response 0xAA22CC44.
- Back-pressure: RSP_DEPTH=2, RspReady=0; issue 3 RDs -> ready drops after 2 accepted; raise RspReady -> 2 responses in order, then the 3rd is accepted.
- Wrap and region: fetch at top byte address 2^ADDR_W-2 -> bytes 2,3 come from addresses 0,1; a RD with a region miss -> no response and no write.
- Collision: same-cycle fetch and WR to 0x20 -> fetch returns old data; a fetch on the next cycle returns new data.
- Parity (I_MEM_PARITY_EN): WR @0x30 with ParInj=1, fetch 0x30 -> IMemParErrQ101H pulses once, sticky=1 until RstQnnnH; without the macro, both flags stay 0.
